// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states and the per-operation step count.
package mdu_pkg;
    localparam int MD_ITERATIONS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction
endpackage

// File: rtl/md_sign_fix.sv
// Signed-operand handling around the unsigned datapath: operand magnitudes on
// the way in, sign restoration and divide-by-zero result on the way out.
module md_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   mag_x,
    output logic [WIDTH-1:0]   mag_y,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic               signed_op, sx, sy;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign sx        = signed_op & x[WIDTH-1];
    assign sy        = signed_op & y[WIDTH-1];

    // Negating the most negative value wraps to itself, which is exactly 2^31 unsigned.
    assign mag_x = sx ? (~x + 1'b1) : x;
    assign mag_y = sy ? (~y + 1'b1) : y;

    assign prod = (sx ^ sy) ? (~raw + 1'b1) : raw;
    assign quot = (sx ^ sy) ? (~raw[WIDTH-1:0] + 1'b1) : raw[WIDTH-1:0];
    assign rem  = sx ? (~raw[2*WIDTH-1:WIDTH] + 1'b1) : raw[2*WIDTH-1:WIDTH];

    always_comb begin
        hi = rem;
        lo = quot;
        if (!is_div_op(op)) begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end else if (y == '0) begin
            // Divide by zero returns the dividend untouched, bypassing sign fixup.
            hi = x;
            lo = '1;
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers;
// one shared 64-bit shift register and one 33-bit adder serve both operations.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       MDOp,
    input  logic             MDStart,
    input  logic [WIDTH-1:0] MDOpX,
    input  logic [WIDTH-1:0] MDOpY,
    output logic             MDBusy,
    output logic             MDDone,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CNT_W = $clog2(MD_ITERATIONS);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [2*WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               idle, div_run;
    logic [2:0]         sf_op;
    logic [WIDTH-1:0]   sf_x, sf_y, mag_x, mag_y, fix_hi, fix_lo;
    logic [WIDTH:0]     add_a, add_b, add_r;
    logic [2*WIDTH-1:0] sr_step;

    // In IDLE the sign logic sees the incoming request so the shift register
    // can be loaded with the dividend/multiplicand magnitude at the start edge.
    assign idle  = (state_q == S_IDLE);
    assign sf_op = idle ? MDOp  : op_q;
    assign sf_x  = idle ? MDOpX : x_q;
    assign sf_y  = idle ? MDOpY : y_q;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op    (sf_op),
        .x     (sf_x),
        .y     (sf_y),
        .raw   (sr_step),
        .mag_x (mag_x),
        .mag_y (mag_y),
        .hi    (fix_hi),
        .lo    (fix_lo)
    );

    assign div_run = is_div_op(op_q);
    assign add_a   = div_run ? sr_q[2*WIDTH-1:WIDTH-1] : {1'b0, sr_q[2*WIDTH-1:WIDTH]};
    assign add_b   = {1'b0, mag_y};
    assign add_r   = div_run ? (add_a - add_b) : (add_a + add_b);

    // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
    always_comb begin
        if (div_run)
            sr_step = add_r[WIDTH] ? {sr_q[2*WIDTH-2:0], 1'b0}
                                   : {add_r[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1};
        else
            sr_step = sr_q[0] ? {add_r, sr_q[WIDTH-1:1]} : {1'b0, sr_q[2*WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        sr_d    = sr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (MDStart) begin
                    case (MDOp)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            op_d    = MDOp;
                            x_d     = MDOpX;
                            y_d     = MDOpY;
                            sr_d    = {{WIDTH{1'b0}}, mag_x};
                            cnt_d   = '0;
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = MDOpX;
                        OP_MTLO: lo_d = MDOpX;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MD_ITERATIONS - 1)) begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    cnt_d   = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sr_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sr_q    <= sr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign MDBusy = busy_q;
    assign MDDone = done_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of mult/div results plus
// hand sequences for HI/LO moves, ignored requests and mid-operation reset.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  MDOp;
    logic        MDStart;
    logic [31:0] MDOpX, MDOpY;
    logic        MDBusy, MDDone;
    logic [31:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .MDOp    (MDOp),
        .MDStart (MDStart),
        .MDOpX   (MDOpX),
        .MDOpY   (MDOpY),
        .MDBusy  (MDBusy),
        .MDDone  (MDDone),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following E33.
    task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic inject,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int busy_n, done_n, first_done;
        bit ended;
        hi0 = HI;
        lo0 = LO;
        MDOp = op; MDOpX = x; MDOpY = y; MDStart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MDStart = 1'b0;
        busy_n = 0; done_n = 0; first_done = -1; ended = 0;
        for (int i = 0; i < 60 && !ended; i++) begin
            if (MDBusy) busy_n++; else ended = 1;
            if (MDDone) begin
                done_n++;
                if (first_done < 0) first_done = i;
            end
            if (i == 16) chk({name, " hold"}, {HI, LO}, {hi0, lo0});
            if (inject && i == 5) begin
                MDOp = OP_DIVU; MDOpX = 32'd9; MDOpY = 32'd3; MDStart = 1'b1;
            end else begin
                MDStart = 1'b0;
            end
            if (!ended) @(negedge clk);
        end
        chk({name, " busy_cycles"}, 64'(busy_n), 64'd33);
        chk({name, " done_at"}, 64'(first_done), 64'd32);
        chk({name, " done_width"}, 64'(done_n), 64'd1);
        chk({name, " HI"}, {32'd0, HI}, {32'd0, exp_hi});
        chk({name, " LO"}, {32'd0, LO}, {32'd0, exp_lo});
    endtask

    task automatic idle_op(input logic [2:0] op, input logic [31:0] x);
        MDOp = op; MDOpX = x; MDOpY = 32'h0; MDStart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MDStart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg3x7",OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"div_min_m1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{"divu_by0",   OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{"divu_100_7", OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{"div_7_m2",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{"div_m8_by0", OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[8]  = '{"mult_minsq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{"mult_min_1", OP_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[10] = '{"divu_max_1", OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{"mult_m1sq",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        rst_n = 1'b0; MDStart = 1'b0; MDOp = '0; MDOpX = '0; MDOpY = '0;
        repeat (3) @(negedge clk);
        chk("reset HI", {32'd0, HI}, 64'd0);
        chk("reset LO", {32'd0, LO}, 64'd0);
        chk("reset busy", {63'd0, MDBusy}, 64'd0);
        chk("reset done", {63'd0, MDDone}, 64'd0);
        rst_n = 1'b1;

        idle_op(OP_MTHI, 32'h12345678);
        chk("mthi HI", {32'd0, HI}, 64'h12345678);
        chk("mthi done", {63'd0, MDDone}, 64'd0);
        chk("mthi busy", {63'd0, MDBusy}, 64'd0);
        idle_op(OP_MTLO, 32'hABCDEF01);
        chk("mtlo LO", {32'd0, LO}, 64'hABCDEF01);
        chk("mtlo HI kept", {32'd0, HI}, 64'h12345678);
        idle_op(3'd6, 32'h55555555);
        chk("reserved HI/LO", {HI, LO}, 64'h12345678_ABCDEF01);
        chk("reserved busy", {63'd0, MDBusy}, 64'd0);

        run_md("multu_5x6_inject", OP_MULTU, 32'd5, 32'd6, 1'b1, 32'h0, 32'h1E);
        chk("inject not queued", {63'd0, MDBusy}, 64'd0);

        for (int v = 0; v < 12; v++)
            run_md(vecs[v].name, vecs[v].op, vecs[v].x, vecs[v].y, 1'b0, vecs[v].hi, vecs[v].lo);

        idle_op(OP_MTHI, 32'hCAFEF00D);
        MDOp = OP_DIVU; MDOpX = 32'd1000; MDOpY = 32'd7; MDStart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MDStart = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset busy", {63'd0, MDBusy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst HI", {32'd0, HI}, 64'd0);
        chk("midrst LO", {32'd0, LO}, 64'd0);
        chk("midrst busy", {63'd0, MDBusy}, 64'd0);
        chk("midrst done", {63'd0, MDDone}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_md("post_reset_multu_2x3", OP_MULTU, 32'd2, 32'd3, 1'b0, 32'h0, 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port MDOp, input, 3, operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
REQ-005 The block SHALL have port MDStart, input, 1, request strobe sampled when MDBusy is low.
REQ-006 The block SHALL have ports MDOpX and MDOpY, input, 32 each: multiplicand/dividend (X) and multiplier/divisor (Y); MTHI/MTLO use X only.
REQ-007 The block SHALL have port MDBusy, output, 1, high while a multiply or divide is in progress.
REQ-008 The block SHALL have port MDDone, output, 1, a one-cycle pulse when HI/LO hold a new mult/div result.
REQ-009 The block SHALL have ports HI and LO, output, 32 each, the architectural HI and LO registers, driven directly from flops.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE, with MDBusy = (state != IDLE).
REQ-011 In IDLE, MDStart with MDOp 0-3 SHALL latch operands and MDOp at that edge (E0) and go to RUN with the iteration counter at 0.
REQ-012 In IDLE, MDStart with MTHI/MTLO SHALL write MDOpX into HI/LO at that edge, stay in IDLE, and SHALL NOT pulse MDDone.
REQ-013 Reserved MDOp codes with MDStart SHALL be ignored.
REQ-014 MDStart while MDBusy is high SHALL be ignored; latched operands SHALL NOT change.
REQ-015 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide.
REQ-016 The 32nd step SHALL occur at edge E32 and SHALL write HI/LO at that edge, with the state going to DONE.
REQ-017 MDDone SHALL be high only in DONE, and DONE SHALL return to IDLE at edge E33.
REQ-018 Back-to-back requests: the earliest next start SHALL be sampled at E33.
REQ-019 HI/LO SHALL keep their previous values while RUN is active.
REQ-020 MULTU SHALL produce a 64-bit unsigned product, with HI = bits 63:32 and LO = bits 31:0.
REQ-021 MULT SHALL operate on the magnitudes and negate the 64-bit product when the operand signs differ.
REQ-022 DIVU SHALL produce LO = quotient and HI = remainder, both unsigned.
REQ-023 DIV SHALL divide the magnitudes, negate the quotient when signs differ, and give the remainder the sign of the dividend.
REQ-024 Magnitude of 0x80000000 SHALL be taken as unsigned 2^31 (no overflow); DIV 0x80000000 / -1 SHALL give LO = 0x80000000, HI = 0.
REQ-025 Divide by zero (DIV or DIVU) SHALL take full latency and give LO = 0xFFFFFFFF, HI = dividend as given (unsigned view).

Reset
REQ-026 When rst_n is low, the block SHALL force state IDLE, counter 0, HI = 0, LO = 0, MDBusy = 0, MDDone = 0 and clear operand registers.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no HI/LO update, and no MDDone SHALL follow release.
REQ-028 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package mdu_pkg SHALL hold the MDOp encodings, the state enum and the constant MD_ITERATIONS = 32.
REQ-030 Sign handling (magnitude extraction and result negation fixup) SHALL be a combinational sub-module md_sign_fix, instanced once.
REQ-031 The block SHALL use a single shared 64-bit shift register (remainder/product) plus a 33-bit adder/subtractor for both multiply and divide.

Verification
REQ-032 Bench case: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; MDDone high exactly one cycle, 32 cycles after the start edge.
REQ-033 Bench case: MULT 0xFFFFFFFD (-3) x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; MDBusy high for 33 cycles.
REQ-034 Bench case: DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-035 Bench case: DIVU 0x64 / 0 -> LO = 0xFFFFFFFF, HI = 0x64 after full latency.
REQ-036 Bench case: MTHI 0x12345678 while IDLE -> HI = 0x12345678 next cycle, no MDDone; then MULTU 5 x 6 with a second MDStart (DIVU 9 / 3) during RUN -> second request ignored, HI = 0, LO = 0x1E.
REQ-037 Bench case: rst_n low at cycle 10 of a DIVU -> HI = LO = 0, MDBusy = 0 immediately; no MDDone after release; new MULTU 2 x 3 -> LO = 6.
